child_start_sequencer: RTL and testbench
========================================

Name: child_start_sequencer

Overview:
- Sequences a parent's NUM_CHILD child instances one at a time, in ascending index order.
- For each child enabled in a mask, it issues a one-cycle start pulse and waits for that child's done before moving to the next.
- It sits in a parent hierarchy module beside its child instances and is the single source of child start strobes.
- It reports busy, completion, current index and, optionally, per-child timeout errors.

Parameters:
- NUM_CHILD, 5, number of sequenced child instances (>=2).
- TIMEOUT_CYCLES, 200, maximum WAIT cycles per child before timeout (used only with SEQ_TIMEOUT_EN).
- TO_W, 8, timeout counter width; requires 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go_i  in  1  start-sequence request; sampled in IDLE only.
- enable_mask_i  in  NUM_CHILD  children to run; latched when go is accepted.
- abort_i  in  1  synchronous abort of the current sequence.
- done_i  in  NUM_CHILD  per-child completion pulse/level.
- start_o  out  NUM_CHILD  one-hot one-cycle start strobe.
- busy_o  out  1  high from the cycle after go is accepted until the return to IDLE.
- done_o  out  1  one-cycle pulse at sequence completion.
- cur_idx_o  out  $clog2(NUM_CHILD)  index currently started or awaited.
- err_o  out  1  sticky timeout flag.
- err_idx_o  out  $clog2(NUM_CHILD)  index of the child that timed out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; every output 0; latched mask 0; timeout counter 0.
  - Reset asserted mid-sequence drops start_o and busy_o immediately; no done_o is issued.
- FSM states: IDLE, SCAN, START, WAIT, FINISH.
- IDLE:
  - go_i=1 latches enable_mask_i, clears err_o/err_idx_o, and moves to SCAN; busy_o=1 from the next cycle.
  - go_i is ignored in every other state.
- SCAN (1 cycle):
  - Selects the lowest set bit of the latched mask into cur_idx_o, then moves to START.
  - If the mask is empty, moves to FINISH.
- START (1 cycle): start_o[cur_idx]=1, all other start_o bits 0; then WAIT.
- WAIT:
  - done_i[cur_idx]=1 clears that mask bit and moves to SCAN.
  - done_i bits of other indices are ignored.
  - done_i high during the START cycle is ignored; only WAIT samples it.
- FINISH (1 cycle): done_o=1, busy_o=0 from the next cycle; then IDLE.
- abort_i in SCAN, START or WAIT:
  - Next state is IDLE, the mask is cleared, start_o drops, no done_o.
  - abort_i has priority over done_i in the same cycle.
  - abort_i in IDLE or FINISH has no effect.
- Latency:
  - go accepted at cycle 0 -> first start_o at cycle 2.
  - done_i sampled at cycle t -> next start_o, or done_o, at cycle t+2.
  - Empty mask: done_o at cycle 2 with no start_o.
- cur_idx_o holds its last value in IDLE. It never exceeds NUM_CHILD-1.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to WAIT and increments each WAIT cycle without a matching done.
  - When it reaches TIMEOUT_CYCLES: err_o=1 (sticky), err_idx_o=cur_idx, remaining mask cleared, next state FINISH, so done_o still pulses.
  - A matching done in the same cycle as the timeout wins; no error is raised.
- Undefined: WAIT has no bound; err_o and err_idx_o are tied 0; no counter logic.

Decomposition:
- Package child_seq_pkg holds:
  - the state enum type seq_state_e;
  - the default NUM_CHILD and TIMEOUT_CYCLES constants;
  - function lowest_set_idx(mask).
- Sub-module seq_timeout_cnt (clear, enable, expired), instantiated only under SEQ_TIMEOUT_EN.

Test Plan:
- mask=5'b10101, go; each done_i returned 3 cycles after its start -> start_o pulses on idx 0, 2, 4 in order, each exactly 1 cycle; done_o at the cycle after the last done +1; busy_o high throughout.
- mask=0, go at cycle 0 -> done_o at cycle 2, start_o stays 0, busy_o high for cycles 1-2 only.
- mask=5'b00011; done_i[1] pulsed while waiting on idx 0 -> ignored; sequence waits for done_i[0], then starts idx 1.
- mask=5'b11111; abort_i while in WAIT on idx 2 -> IDLE next cycle, no done_o, start_o 0; a new go with mask=5'b00001 starts idx 0 normally.
- go asserted again while busy -> ignored; no re-latch and no extra start_o.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=10: mask=5'b00110 and done_i[1] never asserted -> after 10 WAIT cycles err_o=1, err_idx_o=1, done_o pulses, idx 2 never started; the next go clears err_o.

Source files
------------

// File: rtl/child_seq_pkg.sv
// Shared types and helpers for the child start sequencer: state encoding,
// default sizing constants and a lowest-set-bit search used to pick the next child.
package child_seq_pkg;

    localparam int DEF_NUM_CHILD      = 5;
    localparam int DEF_TIMEOUT_CYCLES = 200;
    localparam int DEF_TO_W           = 8;
    // Widest mask the helper function can search; NUM_CHILD must not exceed it.
    localparam int MAX_CHILD          = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    // Index of the lowest set bit; returns 0 for an empty mask (callers test for empty first).
    function automatic int unsigned lowest_set_idx(input logic [MAX_CHILD-1:0] mask);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_CHILD - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Per-child WAIT watchdog. Cleared while the sequencer issues a start, counts
// every enabled cycle, and flags expiry on the cycle whose count would reach LIMIT.
module seq_timeout_cnt #(
    parameter int LIMIT = 200,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [W-1:0] r_cnt;

    // Count enabled WAIT cycles; the START cycle always precedes WAIT, so clearing there restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // LIMIT-th enabled cycle: the counter reaches LIMIT at this edge.
    assign expired_o = enable_i && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/child_start_sequencer.sv
// Sequences NUM_CHILD children one at a time in ascending index order, issuing
// a one-cycle start strobe to each enabled child and waiting for its done.
// Optional per-child WAIT timeout is built when macro SEQ_TIMEOUT_EN is defined.
module child_start_sequencer
    import child_seq_pkg::*;
#(
    parameter int NUM_CHILD      = DEF_NUM_CHILD,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_W           = DEF_TO_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         go_i,
    input  logic [NUM_CHILD-1:0]         enable_mask_i,
    input  logic                         abort_i,
    input  logic [NUM_CHILD-1:0]         done_i,
    output logic [NUM_CHILD-1:0]         start_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(NUM_CHILD)-1:0] cur_idx_o,
    output logic                         err_o,
    output logic [$clog2(NUM_CHILD)-1:0] err_idx_o
);

    localparam int IDX_W = $clog2(NUM_CHILD);

    // Bad configurations leave an empty marker block; it has no hardware.
    if (NUM_CHILD < 2 || NUM_CHILD > MAX_CHILD ||
        (TO_W < 31 && (2 ** TO_W) <= TIMEOUT_CYCLES)) begin : g_bad_cfg
    end

    seq_state_e           r_state;
    seq_state_e           w_state_next;
    logic [NUM_CHILD-1:0] r_mask;
    logic [NUM_CHILD-1:0] w_mask_next;
    logic [IDX_W-1:0]     r_cur_idx;
    logic [IDX_W-1:0]     w_cur_idx_next;
    logic [IDX_W-1:0]     w_scan_idx;
    logic                 w_done_match;
    logic                 w_timeout;

    assign w_scan_idx   = IDX_W'(lowest_set_idx(MAX_CHILD'(r_mask)));
    assign w_done_match = done_i[r_cur_idx];

    // State, remaining-mask and current-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mask    <= '0;
            r_cur_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_mask    <= w_mask_next;
            r_cur_idx <= w_cur_idx_next;
        end
    end

    // Next-state logic: abort beats done, done beats timeout.
    always_comb begin
        w_state_next   = r_state;
        w_mask_next    = r_mask;
        w_cur_idx_next = r_cur_idx;
        unique case (r_state)
            ST_IDLE: begin
                if (go_i) begin
                    w_mask_next  = enable_mask_i;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort_i) begin
                    w_mask_next  = '0;
                    w_state_next = ST_IDLE;
                end else if (r_mask == '0) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_cur_idx_next = w_scan_idx;
                    w_state_next   = ST_START;
                end
            end
            ST_START: begin
                if (abort_i) begin
                    w_mask_next  = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    w_mask_next  = '0;
                    w_state_next = ST_IDLE;
                end else if (w_done_match) begin
                    w_mask_next[r_cur_idx] = 1'b0;
                    w_state_next           = ST_SCAN;
                end else if (w_timeout) begin
                    w_mask_next  = '0;
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // One-hot start strobe decoded from the registered state and index.
    for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_start
        assign start_o[gi] = (r_state == ST_START) && (r_cur_idx == IDX_W'(gi));
    end

    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = (r_state == ST_FINISH);
    assign cur_idx_o = r_cur_idx;

`ifdef SEQ_TIMEOUT_EN
    logic             w_to_clear;
    logic             w_to_enable;
    logic             r_err;
    logic [IDX_W-1:0] r_err_idx;

    assign w_to_clear  = (r_state == ST_START);
    assign w_to_enable = (r_state == ST_WAIT) && !abort_i && !w_done_match;

    seq_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TO_W)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (w_to_clear),
        .enable_i  (w_to_enable),
        .expired_o (w_timeout)
    );

    // Sticky error: cleared when a new sequence is accepted, set on a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_idx <= '0;
        end else if ((r_state == ST_IDLE) && go_i) begin
            r_err     <= 1'b0;
            r_err_idx <= '0;
        end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_err_idx <= r_cur_idx;
        end
    end

    assign err_o     = r_err;
    assign err_idx_o = r_err_idx;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
    assign err_idx_o = '0;
`endif

endmodule

// File: tb/tb_child_start_sequencer.sv
// Self-checking bench for child_start_sequencer: a table of fixed sequences,
// hand-written corner cases and randomized sequences against a timeline model.
module tb_child_start_sequencer;

`ifdef SEQ_TIMEOUT_EN
    localparam int TB_TO = 10;
`else
    localparam int TB_TO = 200;
`endif

    logic       clk;
    logic       rst_n;
    logic       go_i;
    logic [4:0] enable_mask_i;
    logic       abort_i;
    logic [4:0] done_i;
    logic [4:0] start_o;
    logic       busy_o;
    logic       done_o;
    logic [2:0] cur_idx_o;
    logic       err_o;
    logic [2:0] err_idx_o;

    int n_total = 0;
    int n_bad   = 0;

    child_start_sequencer #(
        .NUM_CHILD      (5),
        .TIMEOUT_CYCLES (TB_TO),
        .TO_W           (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go_i          (go_i),
        .enable_mask_i (enable_mask_i),
        .abort_i       (abort_i),
        .done_i        (done_i),
        .start_o       (start_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cur_idx_o     (cur_idx_o),
        .err_o         (err_o),
        .err_idx_o     (err_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] mask;
        int         dly;
        bit         noise;
        int         exp_done;
        int         exp_starts;
    } vec_t;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence. The expected timeline comes from arithmetic on the rules:
    // first start 2 cycles after go, each child occupies (delay + 2) cycles,
    // done_o 2 cycles after the last done, abort in a busy non-final cycle kills the rest.
    task automatic run_seq(input logic [4:0] mask, input int dl[5], input int abort_at,
                           input bit noise, output int done_seen, output int nstarts);
        int         idxs[5];
        int         s[5];
        int         n;
        int         done_cyc;
        int         last_busy;
        int         last;
        bit         aborted;
        logic [4:0] sched[64];
        logic [4:0] nz;
        logic [4:0] exp_start;
        int         exp_idx;

        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (mask[i]) begin
                idxs[n] = i;
                n++;
            end
        end
        done_cyc = 2;
        for (int k = 0; k < n; k++) begin
            s[k] = done_cyc;
            done_cyc += dl[idxs[k]] + 2;
        end
        aborted   = (abort_at >= 1) && (abort_at < done_cyc);
        last_busy = aborted ? abort_at : done_cyc;
        last      = last_busy + 2;

        for (int c = 0; c < 64; c++) sched[c] = '0;
        for (int k = 0; k < n; k++) sched[s[k] + dl[idxs[k]]][idxs[k]] = 1'b1;
        if (noise) begin
            for (int c = 0; c <= last; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    nz = 5'($urandom);
                    // never complete the awaited child early; everything else is fair game
                    for (int k = 0; k < n; k++) begin
                        if (c > s[k] && c < s[k] + dl[idxs[k]]) nz[idxs[k]] = 1'b0;
                    end
                    sched[c] = sched[c] | nz;
                end
            end
        end

        done_seen = -1;
        nstarts   = 0;
        for (int c = 0; c <= last; c++) begin
            go_i          = (c == 0) || (noise && c <= last_busy && $urandom_range(0, 3) == 0);
            enable_mask_i = (c == 0) ? mask : 5'($urandom);
            done_i        = sched[c];
            abort_i       = (c == abort_at);

            exp_start = '0;
            exp_idx   = -1;
            for (int k = 0; k < n; k++) begin
                if (s[k] == c && c <= last_busy) exp_start[idxs[k]] = 1'b1;
                if (c >= s[k] && c <= s[k] + dl[idxs[k]] && c <= last_busy) exp_idx = idxs[k];
            end
            chk("start_o", c, 32'(start_o), 32'(exp_start));
            chk("busy_o", c, 32'(busy_o), 32'(c >= 1 && c <= last_busy));
            chk("done_o", c, 32'(done_o), 32'(!aborted && c == done_cyc));
            if (c >= 1) chk("err_o", c, 32'(err_o), 32'(0));
            if (exp_idx >= 0) chk("cur_idx_o", c, 32'(cur_idx_o), 32'(exp_idx));
            if (start_o != '0) nstarts++;
            if (done_o) done_seen = c;
            step();
        end
        go_i    = 1'b0;
        abort_i = 1'b0;
        done_i  = '0;
        $display("seq mask=%b abort_at=%0d noise=%0d done_cyc=%0d starts=%0d", mask, abort_at, noise, done_seen, nstarts);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   dl[5];
        int   ds;
        int   ns;

        tbl[0] = '{5'b10101, 3, 1'b0, 17, 3};
        tbl[1] = '{5'b00000, 1, 1'b0,  2, 0};
        tbl[2] = '{5'b11111, 1, 1'b1, 17, 5};
        tbl[3] = '{5'b00010, 5, 1'b1,  9, 1};
        tbl[4] = '{5'b01000, 1, 1'b0,  5, 1};
        tbl[5] = '{5'b00011, 2, 1'b1, 10, 2};

        rst_n = 1'b0; go_i = 1'b0; enable_mask_i = '0; abort_i = 1'b0; done_i = '0;
        #3;
        chk("rst_start", 0, 32'(start_o), 32'(0));
        chk("rst_busy", 0, 32'(busy_o), 32'(0));
        chk("rst_done", 0, 32'(done_o), 32'(0));
        chk("rst_idx", 0, 32'(cur_idx_o), 32'(0));
        chk("rst_err", 0, 32'(err_o), 32'(0));
        chk("rst_err_idx", 0, 32'(err_idx_o), 32'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Table of fixed sequences with uniform done latency.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 5; j++) dl[j] = tbl[i].dly;
            run_seq(tbl[i].mask, dl, -1, tbl[i].noise, ds, ns);
            chk("tbl_done_cyc", i, 32'(ds), 32'(tbl[i].exp_done));
            chk("tbl_starts", i, 32'(ns), 32'(tbl[i].exp_starts));
        end

        // Abort while waiting on child 2 (WAIT spans cycles 13..15), then a clean restart.
        for (int j = 0; j < 5; j++) dl[j] = 3;
        run_seq(5'b11111, dl, 14, 1'b0, ds, ns);
        chk("abort_no_done", 0, 32'(ds), 32'(-1));
        chk("abort_starts", 0, 32'(ns), 32'(3));
        for (int j = 0; j < 5; j++) dl[j] = 1;
        run_seq(5'b00001, dl, -1, 1'b0, ds, ns);
        chk("after_abort_done", 0, 32'(ds), 32'(5));
        chk("after_abort_starts", 0, 32'(ns), 32'(1));

        // done_i of another child while waiting on child 0 must not advance the sequence.
        go_i = 1'b1; enable_mask_i = 5'b00011;
        step(); go_i = 1'b0;
        step(); chk("h_start0", 2, 32'(start_o), 32'(5'b00001));
        step(); done_i = 5'b00010;
        step(); done_i = '0;
        chk("h_ignored_start", 4, 32'(start_o), 32'(0));
        chk("h_ignored_idx", 4, 32'(cur_idx_o), 32'(0));
        chk("h_ignored_busy", 4, 32'(busy_o), 32'(1));
        step(); done_i = 5'b00001;
        step(); done_i = '0;
        step(); chk("h_start1", 7, 32'(start_o), 32'(5'b00010));
        chk("h_idx1", 7, 32'(cur_idx_o), 32'(1));
        step(); done_i = 5'b00010;
        step(); done_i = '0;
        step(); chk("h_done", 10, 32'(done_o), 32'(1));
        step(); chk("h_idle", 11, 32'(busy_o), 32'(0));
        $display("hand foreign-done sequence complete");

        // Asynchronous reset during a START cycle drops outputs without a clock edge.
        go_i = 1'b1; enable_mask_i = 5'b11111;
        step(); go_i = 1'b0;
        step(); chk("r_start_before", 2, 32'(start_o), 32'(5'b00001));
        #2 rst_n = 1'b0;
        #1;
        chk("r_start_drop", 2, 32'(start_o), 32'(0));
        chk("r_busy_drop", 2, 32'(busy_o), 32'(0));
        chk("r_done_none", 2, 32'(done_o), 32'(0));
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("r_quiet_start", c, 32'(start_o), 32'(0));
            chk("r_quiet_busy", c, 32'(busy_o), 32'(0));
            chk("r_quiet_done", c, 32'(done_o), 32'(0));
        end
        $display("hand async reset sequence complete");

`ifdef SEQ_TIMEOUT_EN
        // Child 1 never finishes: 10 WAIT cycles (3..12), FINISH at 13, child 2 never started.
        go_i = 1'b1; enable_mask_i = 5'b00110;
        for (int c = 1; c <= 13; c++) begin
            step(); go_i = 1'b0;
            chk("to_start", c, 32'(start_o), 32'((c == 2) ? 5'b00010 : 5'b00000));
            if (c < 13) begin
                chk("to_done_early", c, 32'(done_o), 32'(0));
                chk("to_err_early", c, 32'(err_o), 32'(0));
            end
        end
        chk("to_done", 13, 32'(done_o), 32'(1));
        chk("to_err", 13, 32'(err_o), 32'(1));
        chk("to_err_idx", 13, 32'(err_idx_o), 32'(1));
        step();
        chk("to_idle", 14, 32'(busy_o), 32'(0));
        chk("to_err_sticky", 14, 32'(err_o), 32'(1));
        go_i = 1'b1; enable_mask_i = 5'b00000;
        step(); go_i = 1'b0;
        chk("to_err_clear", 1, 32'(err_o), 32'(0));
        step(); step(); step();
        $display("hand timeout sequence complete");
`endif

        // Randomized sequences against the timeline model.
        for (int r = 0; r < 40; r++) begin
            logic [4:0] m;
            int         ab;
            m  = 5'($urandom);
            for (int j = 0; j < 5; j++) dl[j] = $urandom_range(1, 6);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            run_seq(m, dl, ab, 1'b1, ds, ns);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
